// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope for a single oscillator voice.
// A five-state FSM steps the envelope level once per tick, and a two-stage
// multiply pipeline scales each incoming sample by the current level.
module adsr_envelope #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ENV_WIDTH    = 16,
    parameter int TICK_CYCLES  = 2268
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           gate_in,
    input  logic        [ENV_WIDTH-1:0]    attack_step_in,
    input  logic        [ENV_WIDTH-1:0]    decay_step_in,
    input  logic        [ENV_WIDTH-1:0]    sustain_level_in,
    input  logic        [ENV_WIDTH-1:0]    release_step_in,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    output logic        [ENV_WIDTH-1:0]    env_out,
    output logic                           active_out,
    output logic                           done_out
);

    localparam int CNT_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PROD_W = SAMPLE_WIDTH + ENV_WIDTH + 1;

    localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [ENV_WIDTH-1:0] ENV_MAX   = {ENV_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } state_t;

    state_t                    state_q, state_d;
    logic [ENV_WIDTH-1:0]      env_q, env_d;
    logic [CNT_W-1:0]          tickCnt_q, tickCnt_d;
    logic                      gate_q;
    logic                      done_q, done_d;

    logic                      tick;
    logic                      rise;
    logic                      fall;
    logic [ENV_WIDTH:0]        attackSum;
    logic [ENV_WIDTH:0]        decayFloor;

    logic signed [PROD_W-1:0]       sampleExt;
    logic signed [PROD_W-1:0]       envExt;
    logic signed [PROD_W-1:0]       prod_d, prod_q;
    logic signed [SAMPLE_WIDTH-1:0] scaled_d, scaled_q;
    logic                           validS1_q, validS2_q;

    assign tick      = (tickCnt_q == TICK_LAST);
    assign tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;

    assign rise = gate_in & ~gate_q;
    assign fall = ~gate_in & gate_q;

    // Both operands are widened to the full product width so the multiply is
    // a plain same-width signed multiply; the envelope is zero-extended because
    // it is an unsigned level.
    assign sampleExt = {{(ENV_WIDTH + 1){sample_in[SAMPLE_WIDTH-1]}}, sample_in};
    assign envExt    = {{SAMPLE_WIDTH{1'b0}}, 1'b0, env_q};
    assign prod_d    = sampleExt * envExt;
    assign scaled_d  = SAMPLE_WIDTH'(prod_q >>> ENV_WIDTH);

    // Next state and level: edges take priority and suppress the tick step,
    // otherwise the level advances only on a tick.
    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        done_d     = 1'b0;
        attackSum  = {1'b0, env_q} + {1'b0, attack_step_in};
        decayFloor = {1'b0, sustain_level_in} + {1'b0, decay_step_in};

        if (rise) begin
            state_d = ATTACK;
        end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    env_d = '0;
                end
                ATTACK: begin
                    if (attackSum >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = DECAY;
                    end else begin
                        env_d = attackSum[ENV_WIDTH-1:0];
                    end
                end
                DECAY: begin
                    if ({1'b0, env_q} <= decayFloor) begin
                        env_d   = sustain_level_in;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = env_q - decay_step_in;
                    end
                end
                SUSTAIN: begin
                    env_d = sustain_level_in;
                end
                RELEASE: begin
                    if (env_q <= release_step_in) begin
                        env_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        env_d = env_q - release_step_in;
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Envelope control registers: FSM state, level, tick counter, gate history.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            env_q     <= '0;
            tickCnt_q <= '0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            env_q     <= env_d;
            tickCnt_q <= tickCnt_d;
            gate_q    <= gate_in;
            done_q    <= done_d;
        end
    end

    // Two-stage sample scaling pipeline with a matching valid shift register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            prod_q    <= '0;
            scaled_q  <= '0;
            validS1_q <= 1'b0;
            validS2_q <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            scaled_q  <= scaled_d;
            validS1_q <= sample_valid_in;
            validS2_q <= validS1_q;
        end
    end

    assign sample_out       = scaled_q;
    assign sample_valid_out = validS2_q;
    assign env_out          = env_q;
    assign active_out       = (state_q != IDLE);
    assign done_out         = done_q;

endmodule
